// File: rtl/ram_2.sv
// Byte-addressed little-endian data memory for the load/store unit.
// Supports B/H/3B/W accesses, registered loads with sign/zero extension, and misalignment flagging.
module ram_2 #(
  parameter int DEPTH_BYTES = 8192,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic [31:0]       ram_wdat,
  input  logic              ram_we,
  input  logic [3:0]        ram_type,
  input  logic              sign,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_re,
  output logic [31:0]       data_reg,
  output logic              o_memory_address_misaligned,
  input  logic              rst
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  typedef enum logic [3:0] {
    SZ_B  = 4'b0001,
    SZ_H  = 4'b0011,
    SZ_3B = 4'b0111,
    SZ_W  = 4'b1111
  } size_e;

  logic [7:0]        mem_q [DEPTH_BYTES] = '{default: 8'h00};
  logic [31:0]       data_reg_q, data_reg_d;
  logic [2:0]        nbytes;
  logic              type_ok, misal, in_range, acc_ok, wr_en;
  logic [ADDR_W:0]   last_addr;
  logic [IDX_W-1:0]  baddr [4];
  logic [3:0]        be;
  logic [31:0]       rdata;

  always_comb begin
    nbytes  = '0;
    type_ok = 1'b0;
    misal   = 1'b0;
    case (ram_type)
      SZ_B:  begin nbytes = 3'd1; type_ok = 1'b1; end
      SZ_H:  begin nbytes = 3'd2; type_ok = 1'b1; misal = ram_addr[0]; end
      SZ_3B: begin nbytes = 3'd3; type_ok = 1'b1; misal = |ram_addr[1:0]; end
      SZ_W:  begin nbytes = 3'd4; type_ok = 1'b1; misal = |ram_addr[1:0]; end
      default: ;
    endcase
  end

  // One extra bit so the last touched byte cannot wrap back into range.
  always_comb begin
    last_addr = {1'b0, ram_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    in_range  = last_addr < (ADDR_W+1)'(DEPTH_BYTES);
    acc_ok    = type_ok & ~misal & in_range;
    wr_en     = ram_we & acc_ok & ~rst;
    o_memory_address_misaligned = (ram_we | ram_re) & type_ok & misal;
  end

  always_comb begin
    rdata = '0;
    be    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      baddr[i]       = ram_addr[IDX_W-1:0] + IDX_W'(i);
      be[i]          = (i < 32'(nbytes));
      rdata[8*i +: 8] = be[i] ? mem_q[baddr[i]] : 8'h00;
    end
    case (nbytes)
      3'd1:    rdata[31:8]  = {24{sign & rdata[7]}};
      3'd2:    rdata[31:16] = {16{sign & rdata[15]}};
      3'd3:    rdata[31:24] = {8{sign & rdata[23]}};
      default: ;
    endcase
  end

  always_comb begin
    data_reg_d = data_reg_q;
    if (ram_re & type_ok & ~misal) begin
      data_reg_d = in_range ? rdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_reg_q <= '0;
    else     data_reg_q <= data_reg_d;
  end

  // Reads above sample mem_q before this update, giving read-before-write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[baddr[i]] <= ram_wdat[8*i +: 8];
      end
    end
  end

  assign data_reg = data_reg_q;

endmodule

// File: tb/tb_ram_2.sv
// Directed self-checking bench for ram_2: sizes, extension, alignment, range, RBW and reset.
module tb_ram_2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ram_wdat = '0;
  logic        ram_we = 1'b0;
  logic [3:0]  ram_type = 4'b0000;
  logic        sign = 1'b0;
  logic [31:0] ram_addr = '0;
  logic        ram_re = 1'b0;
  logic [31:0] data_reg;
  logic        flag;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [3:0] T_B = 4'b0001, T_H = 4'b0011, T_3B = 4'b0111, T_W = 4'b1111;

  ram_2 #(.DEPTH_BYTES(8192), .ADDR_W(32)) dut (
    .clk                         (clk),
    .ram_wdat                    (ram_wdat),
    .ram_we                      (ram_we),
    .ram_type                    (ram_type),
    .sign                        (sign),
    .ram_addr                    (ram_addr),
    .ram_re                      (ram_re),
    .data_reg                    (data_reg),
    .o_memory_address_misaligned (flag),
    .rst                         (rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic op(input logic we, input logic re, input logic [3:0] ty, input logic sg,
                    input logic [31:0] addr, input logic [31:0] wd, input logic exp_flag,
                    input string tag);
    @(negedge clk);
    ram_we = we; ram_re = re; ram_type = ty; sign = sg; ram_addr = addr; ram_wdat = wd;
    #1;
    check({tag, "_flag"}, {31'b0, flag}, {31'b0, exp_flag});
    @(posedge clk);
    #1;
    ram_we = 1'b0; ram_re = 1'b0;
  endtask

  task automatic wr(input logic [3:0] ty, input logic [31:0] addr, input logic [31:0] wd,
                    input logic exp_flag, input string tag);
    op(1'b1, 1'b0, ty, 1'b0, addr, wd, exp_flag, tag);
  endtask

  task automatic rd(input logic [3:0] ty, input logic sg, input logic [31:0] addr,
                    input logic [31:0] exp, input logic exp_flag, input string tag);
    op(1'b0, 1'b1, ty, sg, addr, '0, exp_flag, tag);
    check(tag, data_reg, exp);
  endtask

  initial begin
    #1;
    check("reset_data", data_reg, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word round trip
    wr(T_W, 32'h04, 32'h00000011, 1'b0, "w_wr04");
    rd(T_W, 1'b0, 32'h04, 32'h00000011, 1'b0, "w_rd04");

    // Mixed sizes
    wr(T_W, 32'h40, 32'h00000100, 1'b0, "w_wr40");
    wr(T_H, 32'h40, 32'h0000F0F0, 1'b0, "h_wr40");
    wr(T_B, 32'h42, 32'h000000FF, 1'b0, "b_wr42");
    rd(T_H, 1'b0, 32'h40, 32'h0000F0F0, 1'b0, "h_rd40_zx");
    rd(T_B, 1'b1, 32'h42, 32'hFFFFFFFF, 1'b0, "b_rd42_sx");
    rd(T_W, 1'b0, 32'h40, 32'h00FFF0F0, 1'b0, "w_rd40");
    rd(T_H, 1'b1, 32'h40, 32'hFFFFF0F0, 1'b0, "h_rd40_sx");
    rd(T_W, 1'b1, 32'h40, 32'h00FFF0F0, 1'b0, "w_rd40_signign");

    // Misalignment
    rd(T_W, 1'b0, 32'h42, 32'h00FFF0F0, 1'b1, "w_rd42_mis");
    wr(T_H, 32'h41, 32'h00001234, 1'b1, "h_wr41_mis");
    rd(T_W, 1'b0, 32'h40, 32'h00FFF0F0, 1'b0, "w_rd40_after_mis");
    rd(T_3B, 1'b0, 32'h41, 32'h00FFF0F0, 1'b1, "3b_rd41_mis");
    rd(T_B, 1'b0, 32'h43, 32'h00000000, 1'b0, "b_rd43_never_mis");
    op(1'b0, 1'b0, T_W, 1'b0, 32'h42, '0, 1'b0, "idle_mis_addr");
    check("idle_holds", data_reg, 32'h00000000);

    // 3-byte access
    wr(T_3B, 32'h44, 32'hEEABCDEF, 1'b0, "3b_wr44");
    rd(T_W, 1'b0, 32'h44, 32'h00ABCDEF, 1'b0, "w_rd44");
    rd(T_3B, 1'b1, 32'h44, 32'hFFABCDEF, 1'b0, "3b_rd44_sx");
    rd(T_3B, 1'b0, 32'h44, 32'h00ABCDEF, 1'b0, "3b_rd44_zx");

    // Invalid type: no access, no flag, data holds
    rd(4'b0101, 1'b0, 32'h41, 32'h00ABCDEF, 1'b0, "bad_type_rd");
    op(1'b1, 1'b0, 4'b0000, 1'b0, 32'h44, 32'h12345678, 1'b0, "bad_type_wr");
    rd(T_W, 1'b0, 32'h44, 32'h00ABCDEF, 1'b0, "w_rd44_after_bad");

    // Range edges
    wr(T_W, 32'h1FFC, 32'hCAFEF00D, 1'b0, "w_wr1ffc");
    rd(T_W, 1'b0, 32'h1FFC, 32'hCAFEF00D, 1'b0, "w_rd1ffc");
    rd(T_W, 1'b0, 32'h2000, 32'h00000000, 1'b0, "w_rd2000_oor");
    rd(T_B, 1'b1, 32'h1FFF, 32'hFFFFFFCA, 1'b0, "b_rd1fff_sx");
    rd(T_B, 1'b0, 32'h2000, 32'h00000000, 1'b0, "b_rd2000_oor");
    wr(T_W, 32'h2000, 32'hDEADBEEF, 1'b0, "w_wr2000_oor");
    rd(T_W, 1'b0, 32'h0000, 32'h00000000, 1'b0, "w_rd0_nowrap");
    rd(T_W, 1'b0, 32'h1FFC, 32'hCAFEF00D, 1'b0, "w_rd1ffc_kept");
    rd(T_H, 1'b0, 32'h1FFE, 32'h0000CAFE, 1'b0, "h_rd1ffe_zx");
    rd(T_W, 1'b0, 32'hFFFFFFFC, 32'h00000000, 1'b0, "w_rd_top_oor");

    // Simultaneous write and read: read returns old contents
    op(1'b1, 1'b1, T_W, 1'b0, 32'h40, 32'h11111111, 1'b0, "rbw");
    check("rbw_old", data_reg, 32'h00FFF0F0);
    rd(T_W, 1'b0, 32'h40, 32'h11111111, 1'b0, "rbw_new");
    @(negedge clk);
    check("no_re_holds", data_reg, 32'h11111111);

    // Async reset between edges, with a write sampled while rst is high
    #2;
    rst = 1'b1; ram_we = 1'b1; ram_type = T_W; ram_addr = 32'h04; ram_wdat = 32'hBADBAD00;
    #1;
    check("rst_async", data_reg, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold", data_reg, 32'h0);
    @(negedge clk);
    rst = 1'b0; ram_we = 1'b0;
    rd(T_W, 1'b0, 32'h04, 32'h00000011, 1'b0, "mem_kept_rst");
    rd(T_W, 1'b0, 32'h40, 32'h11111111, 1'b0, "mem40_kept_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
